countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter PRESCALE, default 4, sets the number of Clk cycles per count step; legal range 1..255.
REQ-002 Parameter WIDTH, default 4, sets the width of the count value; fixed at 4 for the downstream zero-detect stage.
REQ-003 Clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  is a synchronous, active-high reset.
REQ-005 Load  input  1  copies LoadVal into the count register.
REQ-006 LoadVal  input  4  is the value captured on Load.
REQ-007 Start  input  1  is a single-cycle request to begin counting down.
REQ-008 Pause  input  1  is a level input; while high, counting is held.
REQ-009 AutoReload  input  1  selects automatic reload of the last loaded value on reaching zero.
REQ-010 Count  output  4  is the registered current count; it feeds the zero-detect stage.
REQ-011 Busy  output  1  is high in RUN and PAUSED.
REQ-012 Done  output  1  is a one-Clk pulse, issued on the cycle Count becomes 0 from a step.

Function
REQ-013 The FSM shall have states IDLE, RUN, PAUSED and DONE.
REQ-014 IDLE: Load shall set Count and the reload register to LoadVal; Start with Count != 0 shall go to RUN and clear the prescaler.
REQ-015 IDLE: Start with Count == 0 shall be ignored, with no state change and no Done.
REQ-016 RUN: the prescaler shall count 0..PRESCALE-1; on the wrap cycle, Count shall decrement by 1.
REQ-017 The first decrement shall occur exactly PRESCALE cycles after the Start cycle.
REQ-018 RUN: when a decrement takes Count from 1 to 0, Done shall pulse in that same registered cycle.
REQ-019 On reaching zero with AutoReload=0, the FSM shall go to DONE.
REQ-020 On reaching zero with AutoReload=1, the FSM shall reload Count from the reload register on the next step boundary and stay in RUN.
REQ-021 With AutoReload=1 and a reload value of 0, the FSM shall go to DONE instead of reloading.
REQ-022 RUN with Pause=1 shall go to PAUSED; the prescaler and Count shall freeze.
REQ-023 PAUSED with Pause=0 shall return to RUN and resume from the frozen prescaler value.
REQ-024 DONE shall go to IDLE after one cycle; Count shall remain 0.
REQ-025 Load in RUN or PAUSED shall abort to IDLE, load LoadVal, clear the prescaler and issue no Done.
REQ-026 Load and Start together shall give Load priority; Start shall be ignored that cycle.
REQ-027 Pause and a step boundary in the same cycle shall give Pause priority; no decrement shall occur.
REQ-028 Count shall never wrap below 0; arithmetic is unsigned, 4-bit.
REQ-029 Start in RUN, PAUSED or DONE shall be ignored.

Reset
REQ-030 Rst=1 at a rising Clk edge shall force: state IDLE, Count=0, reload register=0, prescaler=0, Busy=0, Done=0.
REQ-031 Rst shall override all other inputs, including mid-count and on the Done cycle.
REQ-032 Outputs shall be valid from the first edge after reset.

Structure
REQ-033 The state encoding constants and the default PRESCALE value shall reside in a shared package (timer_pkg).
REQ-034 The prescaler shall be a separate sub-module, tick_gen, with inputs Clk, Rst, Clear and Hold, and a one-cycle Tick output.
REQ-035 All outputs shall be registered; there shall be no combinational path from input to output.

Verification
REQ-036 Reset, Load 5, Start, PRESCALE=4 -> Count 5,4,3,2,1,0 at cycles +4,+8,+12,+16,+20; Done pulses once at +20; Busy is 0 afterwards.
REQ-037 Load 3, Start, Pause high for 6 cycles after the first decrement -> Count holds 2 for the pause duration, then resumes; total run time is +6 cycles.
REQ-038 AutoReload=1, Load 2, Start -> Count sequence 2,1,0,2,1,0...; Done pulses each time Count reaches 0; Busy stays 1.
REQ-039 Load 0, Start -> the FSM stays in IDLE; Busy=0 and Done=0.
REQ-040 Mid-count Load 9 at Count=4 -> IDLE, Count=9, no Done; Rst asserted at Count=2 -> all outputs 0 on the next edge.
REQ-041 Load and Start in the same cycle with LoadVal=7 -> Count=7 and the FSM remains in IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default step length.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned PRESCALE_DEFAULT = 4;
    localparam int unsigned WIDTH_DEFAULT    = 4;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..PRESCALE-1 while not held and flags the wrap cycle with Tick.
module tick_gen
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    input  logic Hold,
    output logic Tick
);

    localparam logic [7:0] LAST = 8'(PRESCALE - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (Clear) begin
            cnt_d = '0;
        end else if (!Hold) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Tick = !Rst && !Clear && !Hold && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter stepping once every PRESCALE clocks, with pause and optional auto-reload.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned WIDTH    = WIDTH_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Start,
    input  logic             Pause,
    input  logic             AutoReload,
    output logic [WIDTH-1:0] Count,
    output logic             Busy,
    output logic             Done
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic             pre_clear;

    // Prescaler stays at zero outside an active run so the first step lands PRESCALE cycles after Start.
    assign pre_clear = Load || (state_q == ST_IDLE) || (state_q == ST_DONE);

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .Clk  (Clk),
        .Rst  (Rst),
        .Clear(pre_clear),
        .Hold (Pause),
        .Tick (tick)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (Load) begin
                state_q  <= ST_IDLE;
                count_q  <= LoadVal;
                reload_q <= LoadVal;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (Start && (count_q != '0)) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_RUN, ST_PAUSED: begin
                        state_q <= Pause ? ST_PAUSED : ST_RUN;
                        // tick is already suppressed while Pause is high.
                        if (tick) begin
                            if (count_q == '0) begin
                                count_q <= reload_q;
                            end else begin
                                count_q <= count_q - WIDTH'(1);
                                if (count_q == WIDTH'(1)) begin
                                    done_q <= 1'b1;
                                    if (!(AutoReload && (reload_q != '0))) begin
                                        state_q <= ST_DONE;
                                        busy_q  <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Count = count_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: expected outputs are queued per driven cycle and checked after the edge.
module tb_countdown_timer;

    localparam int unsigned P = 4;

    typedef struct {
        string    tag;
        int       cnt;
        int       busy;
        int       done;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       pause;
    logic       auto_reload;
    logic [3:0] count;
    logic       busy;
    logic       done;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    countdown_timer #(
        .PRESCALE(P),
        .WIDTH   (4)
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .Load      (load),
        .LoadVal   (load_val),
        .Start     (start),
        .Pause     (pause),
        .AutoReload(auto_reload),
        .Count     (count),
        .Busy      (busy),
        .Done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue what the outputs must read after the edge, then compare.
    task automatic step(input logic r, input logic ld, input int lv, input logic st,
                        input logic pa, input logic ar, input int ecnt, input int ebusy,
                        input int edone, input string tag);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst         = r;
        load        = ld;
        load_val    = 4'(lv);
        start       = st;
        pause       = pa;
        auto_reload = ar;
        e.tag  = tag;
        e.cnt  = ecnt;
        e.busy = ebusy;
        e.done = edone;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk_eq({g.tag, ".count"}, int'(count), g.cnt);
        chk_eq({g.tag, ".busy"},  int'(busy),  g.busy);
        chk_eq({g.tag, ".done"},  int'(done),  g.done);
    endtask

    // Load lv, Start, then n cycles with Pause high in [pa,pb] and a stray Start at cycle sa.
    task automatic run_down(input int lv, input logic ar, input int pa, input int pb,
                            input int sa, input int n, input string tag);
        int p;
        int s;
        int ecnt;
        int ebusy;
        int edone;
        logic pz;
        logic adv;
        step(1'b0, 1'b1, lv, 1'b0, 1'b0, ar, lv, 0, 0, {tag, ".load"});
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, ar, lv, (lv != 0) ? 1 : 0, 0, {tag, ".start"});
        p = 0;
        for (int i = 1; i <= n; i++) begin
            pz  = (i >= pa) && (i <= pb);
            adv = !pz;
            if (adv) p++;
            s = p / int'(P);
            ecnt  = 0;
            ebusy = 0;
            edone = 0;
            if (lv == 0) begin
                ecnt = 0;
            end else if (ar) begin
                ecnt  = lv - (s % (lv + 1));
                ebusy = 1;
                edone = (adv && (p % int'(P) == 0) && (s % (lv + 1) == lv)) ? 1 : 0;
            end else if (p < lv * int'(P)) begin
                ecnt  = lv - s;
                ebusy = 1;
            end else begin
                ecnt  = 0;
                edone = (adv && p == lv * int'(P)) ? 1 : 0;
            end
            step(1'b0, 1'b0, 0, (i == sa) ? 1'b1 : 1'b0, pz, ar, ecnt, ebusy, edone,
                 $sformatf("%s.c%0d", tag, i));
        end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        load        = 1'b0;
        load_val    = 4'd0;
        start       = 1'b0;
        pause       = 1'b0;
        auto_reload = 1'b0;

        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "reset0");
        step(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0, 0, 0, 0, "reset1");

        // Plain countdown from 5 with a Start while running.
        run_down(5, 1'b0, 100, 0, 2, 22, "cd5");
        // Pause for six cycles after the first step, Start while paused.
        run_down(3, 1'b0, 5, 10, 7, 22, "pause");
        // Pause coinciding with a step boundary.
        run_down(2, 1'b0, 4, 4, 0, 12, "pbound");
        // Auto-reload, then abort by Load.
        run_down(2, 1'b1, 100, 0, 0, 26, "arld");
        step(1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "arld.abort");
        // Start with a zero count is ignored.
        run_down(0, 1'b0, 100, 0, 2, 4, "zero");

        // Mid-count Load, then reset mid-count.
        run_down(5, 1'b0, 100, 0, 0, 6, "mid");
        step(1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 9, 0, 0, "mid.load9");
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 9, 0, 0, "mid.idle");
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 9, 1, 0, "mid.start");
        for (int i = 1; i <= 28; i++)
            step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 9 - i / int'(P), 1, 0,
                 $sformatf("mid.c%0d", i));
        step(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "mid.rst");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 0, 0, "mid.post");
        step(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 0, 0, 0, "mid.start0");

        // Load and Start together: Load wins, timer stays idle.
        step(1'b0, 1'b1, 7, 1'b1, 1'b0, 1'b0, 7, 0, 0, "ldst");
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 7, 0, 0, "ldst.idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
